// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard controller: Set-2 scan-code constants,
// sequencer states and the key-event record handed to the text-input side.
package ps2_pkg;

    localparam logic [7:0] SC_E0      = 8'hE0;
    localparam logic [7:0] SC_E1      = 8'hE1;
    localparam logic [7:0] SC_F0      = 8'hF0;
    localparam logic [7:0] SC_LSHIFT  = 8'h12;
    localparam logic [7:0] SC_RSHIFT  = 8'h59;
    localparam logic [7:0] SC_CTRL    = 8'h14;
    localparam logic [7:0] SC_CAPS    = 8'h58;
    localparam logic [7:0] SC_BAT     = 8'hAA;
    localparam logic [7:0] SC_PAUSE   = 8'h77;
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_WAIT,
        ST_DECODE,
        ST_EMIT
    } state_e;

    // 'release' is a reserved word, hence 'rel'.
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [7:0] ascii;
    } key_event_t;

    // Self-test / ack / resend / error bytes the keyboard sends outside any key sequence.
    function automatic logic is_filler(input logic [7:0] b);
        return (b == SC_BAT) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational Set-2 make-code to ASCII ROM; each entry holds the unshifted and
// shifted glyph, letters pick their case from shift XOR caps.
module ps2_ascii_lut (
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [15:0] pair;  // {unshifted, shifted}
    logic        is_letter;
    logic        use_upper;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pair = 16'h0000;
        case (code)
            8'h1C: pair = "aA";  8'h32: pair = "bB";  8'h21: pair = "cC";  8'h23: pair = "dD";
            8'h24: pair = "eE";  8'h2B: pair = "fF";  8'h34: pair = "gG";  8'h33: pair = "hH";
            8'h43: pair = "iI";  8'h3B: pair = "jJ";  8'h42: pair = "kK";  8'h4B: pair = "lL";
            8'h3A: pair = "mM";  8'h31: pair = "nN";  8'h44: pair = "oO";  8'h4D: pair = "pP";
            8'h15: pair = "qQ";  8'h2D: pair = "rR";  8'h1B: pair = "sS";  8'h2C: pair = "tT";
            8'h3C: pair = "uU";  8'h2A: pair = "vV";  8'h1D: pair = "wW";  8'h22: pair = "xX";
            8'h35: pair = "yY";  8'h1A: pair = "zZ";
            8'h16: pair = "1!";  8'h1E: pair = "2@";  8'h26: pair = "3#";  8'h25: pair = "4$";
            8'h2E: pair = "5%";  8'h36: pair = "6^";  8'h3D: pair = "7&";  8'h3E: pair = "8*";
            8'h46: pair = "9(";  8'h45: pair = "0)";
            8'h0E: pair = "`~";  8'h4E: pair = "-_";  8'h55: pair = "=+";  8'h54: pair = "[{";
            8'h5B: pair = "]}";  8'h5D: pair = 16'h5C7C; 8'h4C: pair = ";:";  8'h52: pair = 16'h2722;
            8'h41: pair = ",<";  8'h49: pair = ".>";  8'h4A: pair = "/?";
            8'h5A: pair = 16'h0D0D;  8'h66: pair = 16'h0808;  8'h29: pair = 16'h2020;
            8'h0D: pair = 16'h0909;  8'h76: pair = 16'h1B1B;
            default: pair = 16'h0000;
        endcase
        is_letter = (pair[15:8] >= 8'h61) && (pair[15:8] <= 8'h7A);
        use_upper = is_letter ? (shift ^ caps) : shift;
        ascii     = use_upper ? pair[7:0] : pair[15:8];
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard sequencer: pops Set-2 bytes from the receiver FIFO, strips prefixes,
// tracks Shift/Ctrl/Caps and presents one translated key event at a time on valid/ack.
module ps2_kbd_ctrl
    import ps2_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    input  logic       kbd_overflow,
    output logic       kbd_nextdata_n,
    output logic       key_valid,
    input  logic       key_ack,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic [7:0] key_ascii,
    output logic       shift_on,
    output logic       ctrl_on,
    output logic       caps_on,
    output logic       err
);

    state_e     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic       ext_f_q, ext_f_d, brk_f_q, brk_f_d;
    logic [2:0] skip_cnt_q, skip_cnt_d;
    logic       lshift_q, lshift_d, rshift_q, rshift_d;
    logic       lctrl_q, lctrl_d, rctrl_q, rctrl_d;
    logic       caps_q, caps_d, caps_held_q, caps_held_d;
    logic       err_q, err_d;
    key_event_t ev_q, ev_d;
    logic [7:0] lut_ascii;

    assign shift_on = lshift_q | rshift_q;
    assign ctrl_on  = lctrl_q | rctrl_q;
    assign caps_on  = caps_q;

    ps2_ascii_lut u_lut (
        .code  (byte_q),
        .shift (shift_on),
        .caps  (caps_q),
        .ascii (lut_ascii)
    );

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        ext_f_d     = ext_f_q;
        brk_f_d     = brk_f_q;
        skip_cnt_d  = skip_cnt_q;
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        lctrl_d     = lctrl_q;
        rctrl_d     = rctrl_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        ev_d        = ev_q;
        err_d       = err_q | kbd_overflow;

        case (state_q)
            ST_IDLE: begin
                if (kbd_ready) begin
                    byte_d  = kbd_data;
                    state_d = ST_POP;
                end
            end
            ST_POP:  state_d = ST_WAIT;
            ST_WAIT: state_d = ST_DECODE;
            ST_DECODE: begin
                state_d = ST_IDLE;
                if (skip_cnt_q != 3'd0) begin
                    skip_cnt_d = skip_cnt_q - 3'd1;
                end else if (byte_q == SC_E1) begin
                    // Pause has no break code; report it once and swallow the rest of its 8 bytes.
                    skip_cnt_d = PAUSE_TAIL;
                    ev_d       = '{code: SC_PAUSE, ext: 1'b1, rel: 1'b0, ascii: 8'h00};
                    state_d    = ST_EMIT;
                end else if (byte_q == SC_E0) begin
                    ext_f_d = 1'b1;
                end else if (byte_q == SC_F0) begin
                    brk_f_d = 1'b1;
                end else if (!(is_filler(byte_q) && !ext_f_q && !brk_f_q)) begin
                    ev_d.code  = byte_q;
                    ev_d.ext   = ext_f_q;
                    ev_d.rel   = brk_f_q;
                    ev_d.ascii = (ext_f_q || brk_f_q) ? 8'h00 : lut_ascii;
                    if (byte_q == SC_LSHIFT && !ext_f_q) lshift_d = !brk_f_q;
                    if (byte_q == SC_RSHIFT)             rshift_d = !brk_f_q;
                    if (byte_q == SC_CTRL) begin
                        if (ext_f_q) rctrl_d = !brk_f_q;
                        else         lctrl_d = !brk_f_q;
                    end
                    if (byte_q == SC_CAPS) begin
                        if (!brk_f_q && !caps_held_q) caps_d = !caps_q;
                        caps_held_d = !brk_f_q;
                    end
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (key_ack) begin
                    ext_f_d = 1'b0;
                    brk_f_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            byte_q      <= 8'h00;
            ext_f_q     <= 1'b0;
            brk_f_q     <= 1'b0;
            skip_cnt_q  <= 3'd0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            err_q       <= 1'b0;
            ev_q        <= '0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            ext_f_q     <= ext_f_d;
            brk_f_q     <= brk_f_d;
            skip_cnt_q  <= skip_cnt_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            lctrl_q     <= lctrl_d;
            rctrl_q     <= rctrl_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            err_q       <= err_d;
            ev_q        <= ev_d;
        end
    end

    assign kbd_nextdata_n = (state_q != ST_POP);
    assign key_valid      = (state_q == ST_EMIT);
    assign key_code       = ev_q.code;
    assign key_ext        = ev_q.ext;
    assign key_release    = ev_q.rel;
    assign key_ascii      = ev_q.ascii;
    assign err            = err_q;

endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Sequences the PS/2 keyboard receiver: pops raw Set-2 scan-code bytes from the receiver FIFO through its `ready`/`nextdata_n` handshake. Strips E0/F0/E1 prefixes, tracks Shift/Ctrl/Caps state and translates make/break codes into key events carrying ASCII. Each event is held on a valid/ack handshake. Sits between the PS/2 receiver and the terminal/text-input logic.

## Interface
Parameters: none.

- `clk`  in  1  system clock; same clock as the PS/2 receiver
- `clr`  in  1  asynchronous, active-high reset
- `kbd_data`  in  8  receiver FIFO head byte; valid whenever `kbd_ready`=1
- `kbd_ready`  in  1  receiver FIFO non-empty
- `kbd_overflow`  in  1  receiver sticky overflow flag
- `kbd_nextdata_n`  out  1  active-low pop strobe, one cycle per byte
- `key_valid`  out  1  event present; held until acknowledged
- `key_ack`  in  1  consumer accepts event
- `key_code`  out  8  scan code with prefixes removed
- `key_ext`  out  1  event was E0-prefixed (or Pause)
- `key_release`  out  1  break event (F0-prefixed)
- `key_ascii`  out  8  translated ASCII; 0x00 when non-printable
- `shift_on`, `ctrl_on`, `caps_on`  out  1 each  live modifier state
- `err`  out  1  sticky copy of `kbd_overflow`; cleared only by `clr`

## Operation
- FSM states:
  - IDLE: on `kbd_ready`=1, latch `kbd_data` into `byte_r` and go to POP.
  - POP: `kbd_nextdata_n`=0 for exactly this cycle.
  - WAIT: one cycle, lets the receiver update `ready`/`r_ptr`.
  - DECODE.
  - EMIT.
- `kbd_nextdata_n` decodes directly from the state register (POP only); it is 1 in all other states.
- DECODE rules:
  - `skip_cnt`≠0: decrement `skip_cnt`, go to IDLE; no event.
  - 0xE1: set `skip_cnt`=7, load a pending Pause event (code 0x77, ext=1, release=0), go to EMIT.
  - 0xE0: set `ext_f`, go to IDLE.
  - 0xF0: set `brk_f`, go to IDLE.
  - 0xAA, 0xFA, 0xFE, 0x00, 0xFF with no prefix pending: discard, go to IDLE.
  - Any other byte: form an event with code=`byte_r`, ext=`ext_f`, release=`brk_f`; update modifiers; go to EMIT.
- Modifiers (updated in DECODE):
  - `shift_on` = LShift(0x12, ext=0) down OR RShift(0x59) down. Each side is tracked separately; E0 12 (fake shift) is ignored.
  - `ctrl_on` = 0x14 down, with or without ext (L and R tracked separately).
  - `caps_on` toggles on a 0x58 make only when `caps_held`=0. `caps_held` is set on make and cleared on break, so typematic repeats do not re-toggle.
- ASCII:
  - Zero for release events, ext events and unmapped codes.
  - Letters are uppercase when `shift_on` XOR `caps_on`.
  - Digits and punctuation use the shifted glyph when `shift_on`.
  - Ctrl does not alter ASCII.
  - Enter=0x0D, Backspace=0x08, Space=0x20, Tab=0x09, Esc=0x1B.
- EMIT: `key_valid`=1 with all event fields stable. On `key_ack`=1: clear `ext_f`/`brk_f`, drop `key_valid`, go to IDLE.
- `key_ack` outside EMIT is ignored.
- The receiver FIFO absorbs backpressure; overflow is reported through `err` only.

## Timing
- Byte latched at edge N (IDLE, `kbd_ready`=1).
- POP during cycle N+1, WAIT at N+2, DECODE at N+3.
- `key_valid` high from N+4.
- `key_ack` sampled high at edge M: `key_valid`=0 after M; the next byte can be latched at M+1 at the earliest.
- Prefix bytes cost 4 cycles with no event.
- Exactly one `kbd_nextdata_n` low pulse per consumed byte; never two pops without an intervening WAIT.
- Modifier outputs change at the DECODE→EMIT edge, together with the event fields.
- Reset values (async, whenever `clr`=1):
  - state=IDLE, `kbd_nextdata_n`=1.
  - `key_valid`=0; `key_code`=`key_ascii`=0x00; `key_ext`=`key_release`=0.
  - All modifier and `caps_held` flags 0; `ext_f`=`brk_f`=0; `skip_cnt`=0; `err`=0.
- Reset mid-sequence (e.g. after E0 or mid-Pause) discards all partial prefix state.

## Structure
- Shared package `ps2_pkg`:
  - Scan-code constants: SC_E0, SC_E1, SC_F0, SC_LSHIFT, SC_RSHIFT, SC_CTRL, SC_CAPS, SC_BAT=0xAA.
  - FSM state enum.
  - Event struct: code, ext, release, ascii.
- Sub-module `ps2_ascii_lut`:
  - Combinational ROM.
  - Inputs: code[7:0], shift, caps. Output: ascii[7:0].
- `ps2_kbd_ctrl` owns the FSM, prefix flags, `skip_cnt`[2:0], modifier registers and event registers.

## Test plan
- Bytes 1C, then F0 1C, with ack one cycle after valid → two events: (1C, ext=0, rel=0, ascii 0x61), then (1C, rel=1, ascii 0x00); exactly 3 pop pulses in total.
- Sequence 12, 1C, F0 1C, F0 12, 1C → A-press ascii 0x41 with `shift_on`=1; final 1C gives 0x61 with `shift_on`=0.
- 58, 58, 58, F0 58, then 1C → `caps_on`=1 after the first 58 only, 1C gives 0x41; repeat with 12 held → 0x61.
- E0 75, then E0 F0 75 → (75, ext=1, rel=0, ascii 0), then (75, ext=1, rel=1). E0 12 does not set `shift_on`.
- E1 14 77 E1 F0 14 F0 77 → exactly one event (77, ext=1), 8 pops; following 1C decodes normally.
- Hold `key_ack`=0 with 3 bytes queued → `key_valid` and fields stable, no further pops; assert `clr` mid-wait → all outputs at reset values and `kbd_nextdata_n`=1 immediately.
